mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit of the 5-stage RV32I pipeline.
- Consumes the execute stage's memory-side outputs: opcode, funct3, effective address, store data, dest reg/write-enable/ALU result.
- Masters a single-outstanding req/ack data bus, holds the pipeline via stallreq_o while a transfer is in flight, and delivers the aligned, extended load result toward write-back.

Parameters:
- BUS_TIMEOUT, 255: max ACCESS cycles waiting for bus_ack_i before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- aluop_i  in  7  opcode; 7'b0000011 = LOAD, 7'b0100011 = STORE, others = non-memory
- alufun3_i  in  3  funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- mem_addr_i  in  32  effective byte address
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result for non-memory ops
- wd_o  out  5  destination register to write-back
- wreg_o  out  1  write enable to write-back
- wdata_o  out  32  write data to write-back
- stallreq_o  out  1  pipeline hold request
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word-aligned address, {mem_addr[31:2], 2'b00}
- bus_be_o  out  4  byte enables, bit n = byte lane n
- bus_wdata_o  out  32  write data, lane-replicated
- bus_rdata_i  in  32  read data, valid on ack
- bus_ack_i  in  1  transfer complete
- err_o  out  1  one-cycle pulse on timeout or misalign

Behaviour:
- Reset (rst=0, async): state IDLE; bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, captured data, timeout counter, err_o all 0. The combinational outputs follow their rules with state IDLE.
- Memory op = LOAD with funct3 in {000,001,010,100,101}, or STORE with funct3 in {000,001,010}.
  - LOAD/STORE with any other funct3: no access, wreg_o=0, stallreq_o=0.
- Non-memory op in IDLE:
  - wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stallreq_o=0; purely combinational.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On a memory op: stallreq_o=1 combinationally and wreg_o=0.
  - Next edge: register bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o and set bus_req_o=1; go to ACCESS.
- ACCESS:
  - stallreq_o=1, wreg_o=0. Bus outputs are held stable until and including the ack cycle.
  - On bus_ack_i=1: capture bus_rdata_i, clear bus_req_o next edge, go to DONE. Ack is legal in the first ACCESS cycle (zero-wait).
  - Timeout counter increments each ACCESS cycle without ack. When it reaches BUS_TIMEOUT: drop bus_req_o, captured data=0, pulse err_o, go to DONE.
- DONE (one cycle):
  - stallreq_o=0, so the pipeline advances at this edge.
  - Load: wreg_o=wreg_i, wdata_o=extended data. Store: wreg_o=0.
  - Next state is IDLE, and counter clears.
- Minimum latency: 3 cycles (IDLE, ACCESS, DONE); each wait state adds one.
- Load extraction by addr[1:0]:
  - LB/LBU take byte lane addr[1:0]; sign- or zero-extend respectively.
  - LH/LHU take halfword lane addr[1].
  - LW takes the whole word.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{reg2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{reg2[15:0]}}.
  - SW: be = 1111, wdata = reg2.
- Upstream inputs are held stable by the stall while stallreq_o=1.
- Reset asserted mid-ACCESS: bus_req_o drops immediately and no result is written. The bus slave tolerates an abandoned request.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_TRAP_EN.
- Defined: a halfword op with addr[0]=1 or a word op with addr[1:0]!=00 issues no bus request. It goes IDLE→DONE, pulses err_o, wreg_o=0, and stalls one cycle.
- Undefined: misalignment is ignored. Halfwords use addr[1] only; words use the aligned word. No err_o from misalign.

Test Plan:
- LW addr 0x0000_1004, slave acks in first ACCESS cycle with rdata 0xDEAD_BEEF → stallreq_o high 2 cycles; DONE shows wdata_o=0xDEADBEEF, wreg_o=1.
- LB addr 0x...03, rdata 0x80_12_34_56 → wdata_o=0xFFFF_FF80. LBU same stimulus → 0x0000_0080.
- SH addr 0x...02, reg2 0x1234_ABCD, 3 wait states → bus_be_o=1100, bus_wdata_o=0xABCD_ABCD, bus_we_o=1; stall lasts 5 cycles; wreg_o=0.
- ADD result 0x0000_0007 to x5 with no memory op → same-cycle pass-through, stallreq_o never asserted.
- BUS_TIMEOUT=4, LW with no ack → bus_req_o high 4 cycles then low; err_o pulses once; wdata_o=0.
- rst pulled low during ACCESS of SW → bus_req_o=0 asynchronously; after release, state IDLE and the next LW completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding req/ack bus master with lane steering and load extension.
// Optional misalignment trap enabled by defining MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  aluop_i,
  input  logic [2:0]  alufun3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [31:0]   rdata_q;
  logic [CW-1:0] tmo_cnt;
  logic          trap_q;

  logic          is_load, is_store, mem_op, bad_op, misal;
  logic [3:0]    be_c;
  logic [31:0]   st_data_c;
  logic [31:0]   ld_data_c;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Operation decode and store lane steering
  always_comb begin
    is_load  = (aluop_i == OP_LOAD) &&
               (alufun3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_store = (aluop_i == OP_STORE) && (alufun3_i inside {3'b000, 3'b001, 3'b010});
    mem_op   = is_load || is_store;
    bad_op   = ((aluop_i == OP_LOAD) || (aluop_i == OP_STORE)) && !mem_op;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    misal    = ((alufun3_i[1:0] == 2'b01) && mem_addr_i[0]) ||
               ((alufun3_i[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));
`else
    misal    = 1'b0;
`endif
    case (alufun3_i[1:0])
      2'b00: begin
        be_c      = 4'b0001 << mem_addr_i[1:0];
        st_data_c = {4{reg2_i[7:0]}};
      end
      2'b01: begin
        be_c      = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data_c = {2{reg2_i[15:0]}};
      end
      default: begin
        be_c      = 4'b1111;
        st_data_c = reg2_i;
      end
    endcase
  end

  // Load lane extraction and extension from the captured word
  always_comb begin
    ld_byte = rdata_q[{mem_addr_i[1:0], 3'b000} +: 8];
    ld_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (alufun3_i)
      3'b000:  ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_c = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data_c = {24'h0, ld_byte};
      3'b101:  ld_data_c = {16'h0, ld_half};
      default: ld_data_c = rdata_q;
    endcase
  end

  // Control FSM with registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_be_o    <= 4'h0;
      bus_wdata_o <= 32'h0;
      rdata_q     <= 32'h0;
      tmo_cnt     <= '0;
      trap_q      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (misal) begin
              trap_q  <= 1'b1;
              rdata_q <= 32'h0;
              err_o   <= 1'b1;
              state   <= DONE;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store;
              bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
              bus_be_o    <= be_c;
              bus_wdata_o <= st_data_c;
              state       <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus_ack_i) begin
            rdata_q   <= bus_rdata_i;
            bus_req_o <= 1'b0;
            state     <= DONE;
          end else if ((BUS_TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            rdata_q   <= 32'h0;
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          tmo_cnt <= '0;
          trap_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back path and stall request
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
        end else if (bad_op) begin
          wreg_o = 1'b0;
        end
      end
      ACCESS: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
      end
      DONE: begin
        if (is_load && !trap_q) wdata_o = ld_data_c;
        else                    wreg_o  = 1'b0;
      end
      default: wreg_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus queues expected bus requests and write-back results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  aluop_i;
  logic [2:0]  alufun3_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, bus_req_o, bus_we_o, err_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;

  mem_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .alufun3_i(alufun3_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_data;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        err;
    string       name;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int slv_waits = 0;
  int wcnt = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic stall_prev = 1'b0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Bus slave: acks after slv_waits wait states
  always @(negedge clk) begin
    if (bus_req_o) begin
      bus_ack_i   = (wcnt == slv_waits);
      bus_rdata_i = bus_ack_i ? slv_rdata : 32'h0;
      wcnt++;
    end else begin
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0;
      wcnt        = 0;
    end
  end

  // Monitor: new bus request and end of stall are the DUT output events
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
      req_prev   = 1'b0;
    end else begin
      if (bus_req_o && !req_prev) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 32'(bus_req_o), 32'h0);
        end else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          chk({b.name, "_we"}, 32'(bus_we_o), 32'(b.we));
          chk({b.name, "_addr"}, bus_addr_o, b.addr);
          if (b.chk_data) begin
            chk({b.name, "_be"}, 32'(bus_be_o), 32'(b.be));
            chk({b.name, "_bwdata"}, bus_wdata_o, b.wdata);
          end
        end
      end
      if (!stallreq_o && stall_prev) begin
        if (res_q.size() == 0) begin
          chk("result_unexpected", 32'(stallreq_o), 32'h1);
        end else begin
          res_exp_t r;
          r = res_q.pop_front();
          chk({r.name, "_wd"}, 32'(wd_o), 32'(r.wd));
          chk({r.name, "_wreg"}, 32'(wreg_o), 32'(r.wreg));
          if (r.wreg) chk({r.name, "_wdata"}, wdata_o, r.wdata);
          chk({r.name, "_err"}, 32'(err_o), 32'(r.err));
        end
      end
      if (err_o) err_pulses++;
      stall_prev = stallreq_o;
      req_prev   = bus_req_o;
    end
  end

  task automatic drive_nop();
    aluop_i = ALU; alufun3_i = 3'b000; mem_addr_i = 32'h0; reg2_i = 32'h0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
  endtask

  task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] r2, input logic [4:0] wd,
                        input int waits, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                        input logic exp_wreg, input logic [31:0] exp_wdata, input logic exp_err,
                        input int exp_stall, input int exp_req);
    bus_exp_t b;
    res_exp_t r;
    int stall_n = 0;
    int req_n = 0;
    b.we = (op == STORE); b.addr = {addr[31:2], 2'b00}; b.be = exp_be;
    b.wdata = exp_bwdata; b.chk_data = (op == STORE); b.name = nm;
    r.wd = wd; r.wreg = exp_wreg; r.wdata = exp_wdata; r.err = exp_err; r.name = nm;
    @(posedge clk); #1;
    bus_q.push_back(b);
    res_q.push_back(r);
    slv_waits = waits; slv_rdata = rdata;
    aluop_i = op; alufun3_i = f3; mem_addr_i = addr; reg2_i = r2;
    wd_i = wd; wreg_i = 1'b1; wdata_i = 32'h5555_5555;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_req_o) req_n++;
      if (stallreq_o) stall_n++;
      else break;
    end
    chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({nm, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    @(posedge clk); #1;
    drive_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_bus_we", 32'(bus_we_o), 32'h0);
    chk("rst_bus_be", 32'(bus_be_o), 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_stall", 32'(stallreq_o), 32'h0);
    rst = 1'b1;

    run_op("lw", LOAD, 3'b010, 32'h0000_1004, 32'h0, 5'd3, 0, 32'hDEAD_BEEF,
           4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1);
    run_op("lb", LOAD, 3'b000, 32'h0000_2003, 32'h0, 5'd4, 0, 32'h8012_3456,
           4'h0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 2, 1);
    run_op("lbu", LOAD, 3'b100, 32'h0000_2003, 32'h0, 5'd4, 0, 32'h8012_3456,
           4'h0, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 2, 1);
    run_op("lh", LOAD, 3'b001, 32'h0000_2002, 32'h0, 5'd6, 1, 32'h8001_7FFF,
           4'h0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 3, 2);
    run_op("lhu", LOAD, 3'b101, 32'h0000_2000, 32'h0, 5'd7, 1, 32'h8001_FFFE,
           4'h0, 32'h0, 1'b1, 32'h0000_FFFE, 1'b0, 3, 2);
    run_op("sh", STORE, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd8, 3, 32'h0,
           4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0, 5, 4);
    run_op("sb", STORE, 3'b000, 32'h0000_3001, 32'h0000_00A5, 5'd9, 0, 32'h0,
           4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 2, 1);
    run_op("sw", STORE, 3'b010, 32'h0000_4008, 32'h1357_9BDF, 5'd10, 2, 32'h0,
           4'b1111, 32'h1357_9BDF, 1'b0, 32'h0, 1'b0, 4, 3);
    run_op("lw_timeout", LOAD, 3'b010, 32'h0000_6000, 32'h0, 5'd11, 1000, 32'hFFFF_FFFF,
           4'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 5, 4);

    // Non-memory pass-through is combinational and never stalls
    @(posedge clk); #1;
    aluop_i = ALU; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h0000_0007;
    #1;
    chk("add_wd", 32'(wd_o), 32'd5);
    chk("add_wreg", 32'(wreg_o), 32'h1);
    chk("add_wdata", wdata_o, 32'h0000_0007);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add_stall", 32'(stallreq_o), 32'h0);
    end

    // Load with unsupported funct3: no access, no write
    @(posedge clk); #1;
    aluop_i = LOAD; alufun3_i = 3'b011; mem_addr_i = 32'h0000_1000; wreg_i = 1'b1;
    #1;
    chk("badf3_wreg", 32'(wreg_o), 32'h0);
    chk("badf3_stall", 32'(stallreq_o), 32'h0);
    repeat (2) @(negedge clk);
    chk("badf3_req", 32'(bus_req_o), 32'h0);
    @(posedge clk); #1;
    drive_nop();

    // Reset asserted during a store ACCESS
    begin
      bus_exp_t b;
      b.we = 1'b1; b.addr = 32'h0000_5004; b.be = 4'b1111; b.wdata = 32'hCAFE_F00D;
      b.chk_data = 1'b1; b.name = "sw_rst";
      @(posedge clk); #1;
      bus_q.push_back(b);
      slv_waits = 1000;
      aluop_i = STORE; alufun3_i = 3'b010; mem_addr_i = 32'h0000_5004; reg2_i = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      chk("sw_rst_req_before", 32'(bus_req_o), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("sw_rst_req_async", 32'(bus_req_o), 32'h0);
      drive_nop();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("after_rst_stall", 32'(stallreq_o), 32'h0);
      chk("after_rst_req", 32'(bus_req_o), 32'h0);
    end
    run_op("lw_after_rst", LOAD, 3'b010, 32'h0000_7000, 32'h0, 5'd12, 0, 32'h0BAD_F00D,
           4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 2, 1);

    repeat (3) @(negedge clk);
    chk("err_pulse_count", 32'(err_pulses), 32'd1);
    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("res_q_left", 32'(res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
